// File: rtl/axi_mst_write.sv
// AXI-Stream to AXI4 write master: drains a 16-deep stream FIFO into NBURST contiguous INCR bursts.
// Optional build macro AXI_MST_WRITE_ERRCNT_EN adds ERR_REG, a saturating count of non-OKAY write responses.
module axi_mst_write #(
    parameter int ID_WIDTH       = 6,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LENGTH   = 7,
    parameter int B_BURST_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [31:0]               m_axi_awaddr,
    output logic [B_BURST_LENGTH-1:0] m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [1:0]                m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic                      s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                      s_axis_tready,
    input  logic                      START_REG,
    input  logic [31:0]               ADDR_REG,
    input  logic [31:0]               NBURST_REG,
`ifdef AXI_MST_WRITE_ERRCNT_EN
    output logic [31:0]               ERR_REG,
`endif
    output logic                      WIDLE_REG
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = (BURST_LENGTH > 0) ? $clog2(BURST_LENGTH + 1) : 1;
    localparam logic [31:0] ADDR_INC = 32'((BURST_LENGTH + 1) * STRB_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH);

    typedef enum logic [3:0] {
        INIT_ST, START_ST, READ_REGS_ST, ADDR_ST, DATA_ST,
        RESP_ST, NBURST_ST, INCR_ADDR_ST, END_ST
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       nburst_q, nburst_d;
    logic [31:0]       bcnt_q, bcnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              awvalid_q, awvalid_d;
    logic              bready_q, bready_d;
    logic              widle_q, widle_d;

    logic [DATA_WIDTH-1:0] mem [16];
    logic [3:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]            count_q, count_d;
    logic                  fifo_full, fifo_empty, push, pop;

    // bid is never checked (single ID); bresp only feeds the optional error counter
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid, m_axi_bresp};

    assign fifo_full  = (count_q == 5'd16);
    assign fifo_empty = (count_q == 5'd0);
    assign push       = s_axis_tvalid & ~fifo_full;
    assign pop        = m_axi_wvalid & m_axi_wready;

    assign s_axis_tready = ~fifo_full;
    assign m_axi_wdata   = mem[rd_ptr_q];
    assign m_axi_wvalid  = (state_q == DATA_ST) & ~fifo_empty;
    assign m_axi_wlast   = (state_q == DATA_ST) & (beat_q == LAST_BEAT);
    assign m_axi_wstrb   = '1;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = B_BURST_LENGTH'(BURST_LENGTH);
    assign m_axi_awsize  = 3'($clog2(STRB_W));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = '0;
    assign m_axi_awcache = '0;
    assign m_axi_awprot  = '0;
    assign m_axi_awqos   = '0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = bready_q;
    assign WIDLE_REG     = widle_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 4'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 4'd1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        nburst_d = nburst_q;
        bcnt_d   = bcnt_q;
        beat_d   = beat_q;
        case (state_q)
            INIT_ST:  state_d = START_ST;
            START_ST: if (START_REG) state_d = READ_REGS_ST;
            READ_REGS_ST: begin
                addr_d   = ADDR_REG;
                nburst_d = NBURST_REG;
                bcnt_d   = '0;
                state_d  = (NBURST_REG != 32'd0) ? ADDR_ST : END_ST;
            end
            ADDR_ST: begin
                if (m_axi_awready) begin
                    beat_d  = '0;
                    state_d = DATA_ST;
                end
            end
            DATA_ST: begin
                if (pop) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = RESP_ST;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP_ST: begin
                if (m_axi_bvalid) begin
                    bcnt_d  = bcnt_q + 32'd1;
                    state_d = NBURST_ST;
                end
            end
            NBURST_ST:    state_d = (bcnt_q == nburst_q) ? END_ST : INCR_ADDR_ST;
            INCR_ADDR_ST: begin
                addr_d  = addr_q + ADDR_INC;
                state_d = ADDR_ST;
            end
            END_ST:  if (!START_REG) state_d = START_ST;
            default: state_d = INIT_ST;
        endcase
        // Handshake outputs are registered, decoded from the state being entered
        awvalid_d = (state_d == ADDR_ST);
        bready_d  = (state_d == RESP_ST);
        widle_d   = (state_d == START_ST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= INIT_ST;
            addr_q    <= '0;
            nburst_q  <= '0;
            bcnt_q    <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            widle_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nburst_q  <= nburst_d;
            bcnt_q    <= bcnt_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            bready_q  <= bready_d;
            widle_q   <= widle_d;
        end
    end

`ifdef AXI_MST_WRITE_ERRCNT_EN
    logic [31:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == READ_REGS_ST) begin
            err_d = '0;
        end else if ((state_q == RESP_ST) && m_axi_bvalid && (m_axi_bresp != 2'b00)
                     && (err_q != 32'hFFFF_FFFF)) begin
            err_d = err_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR_REG = err_q;
`endif

endmodule
